// File: rtl/binge_session_scheduler_pkg.sv
// Shared types and constants for the binge session scheduler.
// Covers the FSM states, the tracker result field layout and the session end causes.
package binge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_START  = 2'd1,
      ST_RUN    = 2'd2,
      ST_REPORT = 2'd3
   } state_e;

   // Packed tracker result: {person, week, finished, state}
   localparam int TRK_PERSON_MSB = 14;
   localparam int TRK_PERSON_LSB = 12;
   localparam int TRK_WEEK_MSB   = 11;
   localparam int TRK_WEEK_LSB   = 5;
   localparam int TRK_FIN_MSB    = 4;
   localparam int TRK_FIN_LSB    = 3;
   localparam int TRK_ST_MSB     = 2;
   localparam int TRK_ST_LSB     = 0;

   localparam logic [2:0] TRK_ST_F = 3'b110;

   typedef enum logic [1:0] {
      CAUSE_FINISHED  = 2'd0,
      CAUSE_TIMEOUT   = 2'd1,
      CAUSE_ABANDONED = 2'd2
   } cause_e;

   localparam logic [6:0] WEEK_SAT = 7'd127;

   typedef struct packed {
      cause_e     cause;
      logic [6:0] weeks;
   } summary_t;

   function automatic logic [6:0] sat_inc7(input logic [6:0] v);
      return (v == WEEK_SAT) ? v : v + 7'd1;
   endfunction

endpackage

// File: rtl/binge_session_scheduler_if.sv
// Bundle of viewer, tracker and summary signals around the session scheduler.
// master = viewers/tracker side, slave = scheduler.
interface binge_session_scheduler_if #(parameter int N_VIEWERS = 4);
   localparam int IDW = $clog2(N_VIEWERS);

   logic [N_VIEWERS-1:0]   req;
   logic [2*N_VIEWERS-1:0] tl_bus;
   logic [N_VIEWERS-1:0]   grant;
   logic                   busy;
   logic                   trk_rst;
   logic [1:0]             trk_tl;
   logic [14:0]            trk_result;
   logic                   done_valid;
   logic [IDW-1:0]         done_id;
   logic [6:0]             done_weeks;
   logic [1:0]             done_cause;

   modport master (
      output req, tl_bus, trk_result,
      input  grant, busy, trk_rst, trk_tl, done_valid, done_id, done_weeks, done_cause
   );

   modport slave (
      input  req, tl_bus, trk_result,
      output grant, busy, trk_rst, trk_tl, done_valid, done_id, done_weeks, done_cause
   );
endinterface

// File: rtl/binge_session_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// Returns a one-hot pick, its index and whether anything was requesting.
module rr_arbiter #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   pick,
   output logic [IDW-1:0] idx,
   output logic           any
);

   function automatic logic [IDW-1:0] slot(input logic [IDW-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= N) s = s - N;
      return IDW'(s);
   endfunction

   always_comb begin
      pick = '0;
      idx  = '0;
      any  = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!any && req[slot(ptr, k)]) begin
            any             = 1'b1;
            pick[slot(ptr, k)] = 1'b1;
            idx             = slot(ptr, k);
         end
      end
   end

endmodule

// File: rtl/binge_session_scheduler.sv
// Time-shares one binge tracker among N_VIEWERS viewers, one session at a time,
// and emits one summary record (id, weeks, cause) per completed session.
module binge_session_scheduler
   import binge_pkg::*;
#(
   parameter int N_VIEWERS = 4,
   parameter int MAX_WEEKS = 40
) (
   input logic                      clk,
   input logic                      rst,
   binge_session_scheduler_if.slave bus
);

   localparam int             IDW      = $clog2(N_VIEWERS);
   localparam logic [6:0]     WK_LIMIT = 7'(MAX_WEEKS - 1);
   localparam logic [IDW-1:0] LAST_ID  = IDW'(N_VIEWERS - 1);

   state_e                        state_q, state_d;
   logic [IDW-1:0]                id_q, ptr_q, pick_idx, done_id_q;
   logic [N_VIEWERS-1:0]          grant_q, pick_oh;
   logic                          pick_any;
   logic [6:0]                    wk_q, wk_inc;
   logic                          run_end;
   cause_e                        cause_d;
   summary_t                      done_q;
   logic [N_VIEWERS-1:0][1:0]     tl_v;

   assign tl_v = bus.tl_bus;

   rr_arbiter #(.N(N_VIEWERS), .IDW(IDW)) u_arb (
      .req  (bus.req),
      .ptr  (ptr_q),
      .pick (pick_oh),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   assign wk_inc = sat_inc7(wk_q);

   // Tracker finish outranks timeout, which outranks the viewer walking away.
   always_comb begin
      run_end = 1'b0;
      cause_d = CAUSE_FINISHED;
      if (bus.trk_result[TRK_ST_MSB:TRK_ST_LSB] == TRK_ST_F) begin
         run_end = 1'b1;
      end else if (wk_q == WK_LIMIT) begin
         run_end = 1'b1;
         cause_d = CAUSE_TIMEOUT;
      end else if (!bus.req[id_q]) begin
         run_end = 1'b1;
         cause_d = CAUSE_ABANDONED;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (pick_any) state_d = ST_START;
         ST_START:  state_d = ST_RUN;
         ST_RUN:    if (run_end) state_d = ST_REPORT;
         ST_REPORT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.busy       = 1'b0;
      bus.trk_rst    = rst;
      bus.trk_tl     = 2'b00;
      bus.done_valid = 1'b0;
      if (!rst) begin
         case (state_q)
            ST_START: begin
               bus.busy    = 1'b1;
               bus.trk_rst = 1'b1;
            end
            ST_RUN: begin
               bus.busy   = 1'b1;
               bus.trk_tl = tl_v[id_q];
            end
            ST_REPORT: bus.done_valid = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         grant_q   <= '0;
         id_q      <= '0;
         ptr_q     <= '0;
         wk_q      <= '0;
         done_id_q <= '0;
         done_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (pick_any) begin
               grant_q <= pick_oh;
               id_q    <= pick_idx;
            end
            ST_START: wk_q <= '0;
            ST_RUN: begin
               wk_q <= wk_inc;
               if (run_end) begin
                  grant_q      <= '0;
                  done_id_q    <= id_q;
                  done_q.cause <= cause_d;
                  done_q.weeks <= wk_inc;
               end
            end
            ST_REPORT: ptr_q <= (id_q == LAST_ID) ? '0 : id_q + IDW'(1);
            default: ;
         endcase
      end
   end

   assign bus.grant      = grant_q;
   assign bus.done_id    = done_id_q;
   assign bus.done_weeks = done_q.weeks;
   assign bus.done_cause = done_q.cause;

endmodule

// File: tb/tb_binge_session_scheduler.sv
// Scoreboard bench for binge_session_scheduler with a behavioural tracker model:
// directed sessions push expected grants/summaries, a negedge monitor pops and compares.
module tb_binge_session_scheduler;
   import binge_pkg::*;

   localparam int N  = 4;
   localparam int MW = 40;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   binge_session_scheduler_if #(.N_VIEWERS(N)) bus ();

   binge_session_scheduler #(.N_VIEWERS(N), .MAX_WEEKS(MW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Tracker model: NS(0) -> S1..S5 -> F(6), one step per cycle while l&t, F sticky.
   logic [2:0] t_st;
   logic [6:0] t_wk;
   logic [2:0] t_person = 3'd0;
   always @(posedge clk) begin
      if (bus.trk_rst) begin
         t_st     <= 3'd0;
         t_wk     <= 7'd0;
         t_person <= t_person + 3'd1;
      end else begin
         if (t_wk != 7'd127) t_wk <= t_wk + 7'd1;
         if (t_st != TRK_ST_F && bus.trk_tl == 2'b11) t_st <= t_st + 3'd1;
      end
   end
   assign bus.trk_result = {t_person, t_wk, (t_st == TRK_ST_F) ? 2'b01 : 2'b00, t_st};

   typedef struct {int id; int weeks; int cause;} rec_t;
   rec_t           exp_q[$];
   logic [N-1:0]   gexp_q[$];
   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_done(input int n);
      int seen = 0;
      for (int c = 0; c < 300 * n && seen < n; c++) begin
         @(negedge clk);
         if (bus.done_valid) seen++;
      end
      if (seen < n) chk("wait_done_timeout", seen, n);
   endtask

   task automatic wait_start();
      int hit = 0;
      for (int c = 0; c < 300 && hit == 0; c++) begin
         @(negedge clk);
         if (bus.trk_rst && !rst) hit = 1;
      end
      if (hit == 0) chk("wait_start_timeout", hit, 1);
   endtask

   // Monitor
   initial begin
      logic [N-1:0] gprev;
      int rst_cnt;
      rec_t r;
      gprev   = '0;
      rst_cnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            gprev   = '0;
            rst_cnt = 0;
         end else begin
            if (bus.trk_rst) rst_cnt++;
            if (bus.grant != '0 && gprev == '0) begin
               if (gexp_q.size() == 0) chk("grant_unexpected", int'(bus.grant), 0);
               else chk("grant_order", int'(bus.grant), int'(gexp_q.pop_front()));
               chk("grant_onehot", int'($onehot(bus.grant)), 1);
            end
            gprev = bus.grant;
            if (bus.done_valid) begin
               if (exp_q.size() == 0) begin
                  chk("done_unexpected", 1, 0);
               end else begin
                  r = exp_q.pop_front();
                  chk("done_id", int'(bus.done_id), r.id);
                  chk("done_weeks", int'(bus.done_weeks), r.weeks);
                  chk("done_cause", int'(bus.done_cause), r.cause);
                  chk("trk_rst_pulse_cycles", rst_cnt, 1);
               end
               rst_cnt = 0;
            end
         end
      end
   end

   // Stimulus
   initial begin
      rst        = 1'b1;
      bus.req    = '0;
      bus.tl_bus = '0;

      // 1: reset state
      repeat (2) begin
         @(negedge clk);
         chk("rst_trk_rst", int'(bus.trk_rst), 1);
         chk("rst_grant", int'(bus.grant), 0);
         chk("rst_busy", int'(bus.busy), 0);
         chk("rst_done_valid", int'(bus.done_valid), 0);
      end
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("idle_trk_rst", int'(bus.trk_rst), 0);
         chk("idle_busy", int'(bus.busy), 0);
         chk("idle_grant", int'(bus.grant), 0);
      end

      // 2: viewer1 finishes the show
      gexp_q.push_back(4'b0010);
      exp_q.push_back('{1, 7, 0});
      bus.tl_bus = 8'b00_00_11_00;
      bus.req    = 4'b0010;
      wait_done(1);
      bus.req = '0;

      // 3: viewer0 t-only, times out
      gexp_q.push_back(4'b0001);
      exp_q.push_back('{0, MW, 1});
      bus.tl_bus = 8'b00_00_00_01;
      bus.req    = 4'b0001;
      wait_done(1);
      bus.req = '0;

      // 4: all request, pointer from 0 after reset
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      gexp_q.push_back(4'b0001); exp_q.push_back('{0, 7, 0});
      gexp_q.push_back(4'b0010); exp_q.push_back('{1, 7, 0});
      gexp_q.push_back(4'b0100); exp_q.push_back('{2, 7, 0});
      gexp_q.push_back(4'b1000); exp_q.push_back('{3, 7, 0});
      gexp_q.push_back(4'b0001); exp_q.push_back('{0, 7, 0});
      bus.tl_bus = 8'hFF;
      bus.req    = 4'b1111;
      wait_done(5);
      bus.req = '0;

      // 5a: viewer2 drops req in RUN cycle 3
      gexp_q.push_back(4'b0100);
      exp_q.push_back('{2, 3, 2});
      bus.req = 4'b0100;
      wait_start();
      repeat (3) @(posedge clk);
      #1 bus.req = '0;
      wait_done(1);

      // 5b: drop coincides with F observed -> finished wins
      gexp_q.push_back(4'b0100);
      exp_q.push_back('{2, 7, 0});
      bus.req = 4'b0100;
      wait_start();
      repeat (7) @(posedge clk);
      #1 bus.req = '0;
      wait_done(1);

      // 6: reset mid-RUN aborts silently, next session restarts at viewer0
      gexp_q.push_back(4'b1000);
      bus.req = 4'b1000;
      wait_start();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      bus.req = 4'b1001;
      @(posedge clk);
      @(negedge clk);
      chk("abort_grant", int'(bus.grant), 0);
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_done_valid", int'(bus.done_valid), 0);
      chk("abort_trk_rst", int'(bus.trk_rst), 1);
      gexp_q.push_back(4'b0001);
      exp_q.push_back('{0, 7, 0});
      rst = 1'b0;
      wait_done(1);
      bus.req = '0;

      repeat (4) @(negedge clk);
      chk("summaries_outstanding", exp_q.size(), 0);
      chk("grants_outstanding", gexp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
